// File: rtl/chime_alarm_gen.sv
// chime_alarm_gen: hourly pip chime plus daily alarm, producing a registered
// square-wave tone for the speaker driver.
//
// Handshake/timing contract: inputs are sampled every CP, but decisions are
// taken only on SEC_TICK cycles (TIME_* already hold the new second). The
// action takes effect on the next CP and holds until the next SEC_TICK.
// ALM_STOP / ALM_EN=0 cancel the alarm on any cycle, one CP later.
module chime_alarm_gen #(
    parameter int CLK_HZ    = 1_000_000,
    parameter int LOW_HZ    = 500,
    parameter int HIGH_HZ   = 1000,
    parameter int N_PIPS    = 4,
    parameter int ALARM_SEC = 60
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       SEC_TICK,
    input  logic [7:0] TIME_H,
    input  logic [7:0] TIME_M,
    input  logic [7:0] TIME_S,
    input  logic       CHIME_EN,
    input  logic       ALM_EN,
    input  logic [7:0] ALM_H,
    input  logic [7:0] ALM_M,
    input  logic       ALM_STOP,
    output logic       AUDIO,
    output logic       PIP,
    output logic       ALARM_ON
);

    // Tone divider sizing: the counter runs 0..half-1 and toggles AUDIO on wrap.
    localparam int LO_HALF  = CLK_HZ / (2 * LOW_HZ);
    localparam int HI_HALF  = CLK_HZ / (2 * HIGH_HZ);
    localparam int MAX_HALF = (LO_HALF > HI_HALF) ? LO_HALF : HI_HALF;
    localparam int DIV_W    = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;

    localparam logic [DIV_W-1:0] LO_TOP = DIV_W'(LO_HALF - 1);
    localparam logic [DIV_W-1:0] HI_TOP = DIV_W'(HI_HALF - 1);

    // Earliest pip second (binary); pips sit on odd seconds up to 59.
    localparam logic [7:0] PIP_FIRST = 8'(59 - 2 * (N_PIPS - 1));
    // Remaining-seconds value loaded when the alarm starts.
    localparam logic [7:0] ALM_LOAD  = 8'(ALARM_SEC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        A_SND = 2'd1,
        A_SIL = 2'd2
    } alm_state_e;

    alm_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              pip_q, pip_d;
    logic              pip_hi_q, pip_hi_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              audio_q, audio_d;

    logic [7:0]        sec_bin;
    logic              pip_hit;
    logic              pip_top;
    logic              alm_match;
    logic              alm_cancel;
    logic              snd_d;
    logic [DIV_W-1:0]  half_top;

    // Decode the BCD second and the per-tick trigger conditions.
    always_comb begin
        sec_bin    = ({4'd0, TIME_S[7:4]} * 8'd10) + {4'd0, TIME_S[3:0]};
        pip_hit    = CHIME_EN && (TIME_M == 8'h59) && (TIME_S[3:0] <= 4'd9) &&
                     sec_bin[0] && (sec_bin >= PIP_FIRST) && (sec_bin <= 8'd59);
        pip_top    = (TIME_S == 8'h59);
        alm_match  = ALM_EN && (TIME_H == ALM_H) && (TIME_M == ALM_M) &&
                     (TIME_S == 8'h00);
        alm_cancel = ALM_STOP || !ALM_EN;
    end

    // Next-state logic: pip latch per second, alarm FSM, tone divider.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pip_d    = pip_q;
        pip_hi_d = pip_hi_q;
        div_d    = div_q;
        audio_d  = audio_q;

        if (SEC_TICK) begin
            pip_d    = pip_hit;
            pip_hi_d = pip_top;
        end

        // Cancel wins over both the trigger and the per-second advance.
        if (alm_cancel) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (SEC_TICK) begin
            case (state_q)
                IDLE: begin
                    if (alm_match) begin
                        state_d = A_SND;
                        cnt_d   = ALM_LOAD;
                    end
                end
                A_SND, A_SIL: begin
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        state_d = (state_q == A_SND) ? A_SIL : A_SND;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A pip owns the speaker; otherwise the alarm's sounding second does.
        snd_d    = pip_d || (state_d == A_SND);
        half_top = (pip_d && !pip_hi_d) ? LO_TOP : HI_TOP;

        if (SEC_TICK || !snd_d) begin
            div_d   = '0;
            audio_d = 1'b0;
        end else if (div_q == half_top) begin
            div_d   = '0;
            audio_d = ~audio_q;
        end else begin
            div_d   = div_q + DIV_W'(1);
            audio_d = audio_q;
        end
    end

    // State and output registers.
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pip_q    <= 1'b0;
            pip_hi_q <= 1'b0;
            div_q    <= '0;
            audio_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pip_q    <= pip_d;
            pip_hi_q <= pip_hi_d;
            div_q    <= div_d;
            audio_q  <= audio_d;
        end
    end

    assign AUDIO    = audio_q;
    assign PIP      = pip_q;
    assign ALARM_ON = (state_q != IDLE);

endmodule

// File: tb/tb_chime_alarm_gen.sv
// Testbench for chime_alarm_gen: table of per-second steps, hand sequences
// for stop/overlap/reset corners, and a randomized phase, all checked every
// cycle against a second-level behavioural model.
module tb_chime_alarm_gen;

    localparam int CLK_HZ  = 10_000;
    localparam int LOW_HZ  = 500;
    localparam int HIGH_HZ = 1000;
    localparam int N_PIPS  = 4;
    localparam int LO_HALF = CLK_HZ / (2 * LOW_HZ);
    localparam int HI_HALF = CLK_HZ / (2 * HIGH_HZ);
    // Seconds are time-compressed: the DUT only sees SEC_TICK, not real time.
    localparam int SEC_LEN = 100;

    // ---------------- clock / reset / signals ----------------
    logic       CP = 1'b0;
    logic       nCR, SEC_TICK, CHIME_EN, ALM_EN, ALM_STOP;
    logic [7:0] TIME_H, TIME_M, TIME_S, ALM_H, ALM_M;
    logic       aud0, pip0, alon0;
    logic       aud1, pip1, alon1;

    always #5 CP = ~CP;

    chime_alarm_gen #(
        .CLK_HZ(CLK_HZ), .LOW_HZ(LOW_HZ), .HIGH_HZ(HIGH_HZ),
        .N_PIPS(N_PIPS), .ALARM_SEC(6)
    ) u_dut (
        .CP(CP), .nCR(nCR), .SEC_TICK(SEC_TICK),
        .TIME_H(TIME_H), .TIME_M(TIME_M), .TIME_S(TIME_S),
        .CHIME_EN(CHIME_EN), .ALM_EN(ALM_EN), .ALM_H(ALM_H), .ALM_M(ALM_M),
        .ALM_STOP(ALM_STOP), .AUDIO(aud0), .PIP(pip0), .ALARM_ON(alon0)
    );

    chime_alarm_gen #(
        .CLK_HZ(CLK_HZ), .LOW_HZ(LOW_HZ), .HIGH_HZ(HIGH_HZ),
        .N_PIPS(N_PIPS), .ALARM_SEC(90)
    ) u_dut_long (
        .CP(CP), .nCR(nCR), .SEC_TICK(SEC_TICK),
        .TIME_H(TIME_H), .TIME_M(TIME_M), .TIME_S(TIME_S),
        .CHIME_EN(CHIME_EN), .ALM_EN(ALM_EN), .ALM_H(ALM_H), .ALM_M(ALM_M),
        .ALM_STOP(ALM_STOP), .AUDIO(aud1), .PIP(pip1), .ALARM_ON(alon1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    bit m_pip, m_hi;
    bit m_act [2];
    int m_el  [2];
    int m_k;

    function automatic int asec(input int i);
        return (i == 0) ? 6 : 90;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic bit is_pip_sec(input logic [7:0] s);
        for (int k = 0; k < N_PIPS; k++)
            if (s == to_bcd(59 - 2 * k)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_pip = 0; m_hi = 0; m_k = 0;
        for (int i = 0; i < 2; i++) begin m_act[i] = 0; m_el[i] = 0; end
    endtask

    task automatic model_step();
        bit cancel;
        if (!nCR) begin model_reset(); return; end
        cancel = ALM_STOP || !ALM_EN;
        if (SEC_TICK) begin
            m_k   = 0;
            m_pip = CHIME_EN && (TIME_M == 8'h59) && is_pip_sec(TIME_S);
            m_hi  = (TIME_S == 8'h59);
            for (int i = 0; i < 2; i++) begin
                if (cancel) m_act[i] = 0;
                else if (m_act[i]) begin
                    m_el[i]++;
                    if (m_el[i] >= asec(i)) m_act[i] = 0;
                end else if (TIME_H == ALM_H && TIME_M == ALM_M && TIME_S == 8'h00) begin
                    m_act[i] = 1;
                    m_el[i]  = 0;
                end
            end
        end else begin
            m_k++;
            if (cancel) for (int i = 0; i < 2; i++) m_act[i] = 0;
        end
    endtask

    // {AUDIO, PIP, ALARM_ON} the model requires for instance i.
    function automatic logic [2:0] exp_out(input int i);
        bit   snd;
        int   half;
        logic a;
        snd  = m_pip || (m_act[i] && (m_el[i] % 2 == 0));
        half = (m_pip && !m_hi) ? LO_HALF : HI_HALF;
        a    = snd && (((m_k / half) % 2) == 1);
        return {a, m_pip, m_act[i]};
    endfunction

    function automatic logic [2:0] dut_out(input int i);
        return (i == 0) ? {aud0, pip0, alon0} : {aud1, pip1, alon1};
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t time=%02h:%02h:%02h got=%0d want=%0d",
                     name, $time, TIME_H, TIME_M, TIME_S, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (dut_out(i) !== exp_out(i)) begin
                n_errors++;
                $display("FAIL %s%0d @%0t time=%02h:%02h:%02h {audio,pip,alarm_on} got=%b want=%b",
                         name, i, $time, TIME_H, TIME_M, TIME_S, dut_out(i), exp_out(i));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge CP);
        model_step();
        @(negedge CP);
        check_model("cyc");
    endtask

    task automatic set_time(input int h, input int m, input int s);
        TIME_H = to_bcd(h); TIME_M = to_bcd(m); TIME_S = to_bcd(s);
    endtask

    task automatic tick_sec(input int h, input int m, input int s);
        set_time(h, m, s);
        SEC_TICK = 1'b1;
        cycle();
        SEC_TICK = 1'b0;
    endtask

    task automatic run_sec(input int h, input int m, input int s, input int len);
        tick_sec(h, m, s);
        repeat (len - 1) cycle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int h, m, s;
        bit chime, alm_en;
        bit exp_pip, exp_alm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int h, input int m, input int s, input bit chime,
                       input bit alm_en, input bit exp_pip, input bit exp_alm);
        vec_t v;
        v.h = h; v.m = m; v.s = s; v.chime = chime; v.alm_en = alm_en;
        v.exp_pip = exp_pip; v.exp_alm = exp_alm;
        tbl.push_back(v);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        nCR = 1'b0; SEC_TICK = 1'b0; CHIME_EN = 1'b1; ALM_EN = 1'b0; ALM_STOP = 1'b0;
        ALM_H = 8'h07; ALM_M = 8'h30;
        set_time(0, 0, 0);
        model_reset();

        // Chime sweep enabled, then disabled, then alarm run to completion.
        for (int s = 50; s <= 59; s++)
            add(23, 59, s, 1, 0, (s == 53 || s == 55 || s == 57 || s == 59), 0);
        add(0, 0, 0, 1, 0, 0, 0);
        for (int s = 50; s <= 59; s++) add(23, 59, s, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(7, 29, 58, 1, 1, 0, 0);
        add(7, 29, 59, 1, 1, 0, 0);
        for (int s = 0; s <= 7; s++) add(7, 30, s, 1, 1, 0, (s <= 5));

        // Reset state.
        @(negedge CP);
        @(negedge CP);
        check_model("reset");
        nCR = 1'b1;
        repeat (5) cycle();

        foreach (tbl[j]) begin
            CHIME_EN = tbl[j].chime;
            ALM_EN   = tbl[j].alm_en;
            tick_sec(tbl[j].h, tbl[j].m, tbl[j].s);
            check_int("tbl_pip", pip0, tbl[j].exp_pip);
            check_int("tbl_alarm_on", alon0, tbl[j].exp_alm);
            repeat (SEC_LEN - 1) cycle();
        end

        // Alarm stop mid-second 02, then no retrigger until the time matches.
        ALM_EN = 1'b0; cycle(); ALM_EN = 1'b1;
        run_sec(7, 29, 59, SEC_LEN);
        run_sec(7, 30, 0, SEC_LEN);
        run_sec(7, 30, 1, SEC_LEN);
        tick_sec(7, 30, 2);
        repeat (40) cycle();
        ALM_STOP = 1'b1; cycle(); ALM_STOP = 1'b0;
        check_int("stop_alarm_on0", alon0, 0);
        check_int("stop_alarm_on1", alon1, 0);
        check_int("stop_audio0", aud0, 0);
        check_int("stop_audio1", aud1, 0);
        set_time(7, 30, 0);
        repeat (57) cycle();
        check_int("jump_no_tick", alon0, 0);
        for (int s = 3; s <= 5; s++) run_sec(7, 30, s, SEC_LEN);
        ALM_STOP = 1'b1;
        tick_sec(7, 30, 0);
        check_int("stop_prio", alon0, 0);
        repeat (SEC_LEN - 1) cycle();
        ALM_STOP = 1'b0;
        run_sec(7, 29, 59, SEC_LEN);
        tick_sec(7, 30, 0);
        check_int("rearm", alon0, 1);
        repeat (SEC_LEN - 1) cycle();
        tick_sec(7, 30, 0);
        repeat (5) cycle();
        check_int("no_retrig", aud0, 0);
        repeat (SEC_LEN - 6) cycle();

        // Overlap: 90 s alarm at 08:59 underneath the hourly pips.
        ALM_EN = 1'b0; cycle(); ALM_EN = 1'b1;
        ALM_H = 8'h08; ALM_M = 8'h59; CHIME_EN = 1'b1;
        run_sec(8, 58, 59, 20);
        for (int s = 0; s <= 52; s++) run_sec(8, 59, s, 12);
        tick_sec(8, 59, 53);
        check_int("ovl_pip", pip1, 1);
        check_int("ovl_alarm_on", alon1, 1);
        repeat (5) cycle();
        check_int("ovl_low_tone", aud1, 0);
        repeat (SEC_LEN - 6) cycle();
        run_sec(8, 59, 54, SEC_LEN);
        tick_sec(8, 59, 55);
        repeat (20) cycle();
        CHIME_EN = 1'b0;
        repeat (20) cycle();
        check_int("chime_en_mid", pip1, 1);
        repeat (SEC_LEN - 41) cycle();
        CHIME_EN = 1'b1;
        for (int s = 56; s <= 59; s++) run_sec(8, 59, s, SEC_LEN);
        run_sec(9, 0, 0, 30);

        // Reset in the middle of pip 57 with the long alarm still running.
        run_sec(23, 59, 55, SEC_LEN);
        run_sec(23, 59, 56, SEC_LEN);
        tick_sec(23, 59, 57);
        repeat (29) cycle();
        check_int("pre_rst_alarm_on1", alon1, 1);
        #3 nCR = 1'b0;
        model_reset();
        #1;
        check_int("rst_async0", int'({aud0, pip0, alon0}), 0);
        check_int("rst_async1", int'({aud1, pip1, alon1}), 0);
        repeat (4) cycle();
        nCR = 1'b1;
        repeat (60) cycle();
        run_sec(23, 59, 58, SEC_LEN);
        tick_sec(23, 59, 59);
        check_int("rst_pip59", pip0, 1);
        check_int("rst_no_resume", alon1, 0);
        repeat (SEC_LEN - 1) cycle();

        // Randomized seconds with stray stop pulses and chime toggles.
        for (int r = 0; r < 80; r++) begin
            int h, m, s, len;
            h = ($urandom_range(0, 3) == 0) ? 8 : $urandom_range(0, 23);
            m = ($urandom_range(0, 2) != 0) ? 59 : $urandom_range(0, 59);
            case ($urandom_range(0, 3))
                0:       s = 0;
                1:       s = $urandom_range(0, 59);
                default: s = $urandom_range(48, 59);
            endcase
            CHIME_EN = ($urandom_range(0, 3) != 0);
            ALM_EN   = ($urandom_range(0, 9) != 0);
            ALM_STOP = ($urandom_range(0, 19) == 0);
            tick_sec(h, m, s);
            ALM_STOP = 1'b0;
            len = $urandom_range(12, 60);
            for (int c = 1; c < len; c++) begin
                if ($urandom_range(0, 149) == 0) ALM_STOP = 1'b1;
                if ($urandom_range(0, 39) == 0) CHIME_EN = ~CHIME_EN;
                cycle();
                ALM_STOP = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
